// File: rtl/counter_4040_seq.sv
// Sequencer for an external 12-bit '4040-style ripple counter: clears it,
// drives a programmed number of clock pulses and verifies each settled value
// against an internal shadow count.
module counter_4040_seq #(
    parameter int unsigned WIDTH         = 12,
    parameter int unsigned CLR_CYCLES    = 2,
    parameter int unsigned HIGH_CYCLES   = 1,
    parameter int unsigned LOW_CYCLES    = 1,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_clk,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] count
);

    localparam int unsigned MAX_AB  = (CLR_CYCLES > HIGH_CYCLES) ? CLR_CYCLES : HIGH_CYCLES;
    localparam int unsigned MAX_CD  = (LOW_CYCLES > SETTLE_CYCLES) ? LOW_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [PH_W-1:0] CLR_LAST    = PH_W'(CLR_CYCLES - 1);
    localparam logic [PH_W-1:0] HIGH_LAST   = PH_W'(HIGH_CYCLES - 1);
    localparam logic [PH_W-1:0] LOW_LAST    = PH_W'(LOW_CYCLES - 1);
    localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        CHECK,
        PULSE_HI,
        PULSE_LO,
        FINISH,
        ABORT
    } state_t;

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [WIDTH-1:0] tgt;

    // Sequencer state machine; all counter-facing and status outputs registered.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            phase   <= '0;
            tgt     <= '0;
            cnt_clk <= 1'b0;
            cnt_clr <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE) && (state != FINISH) && (state != ABORT)) begin
                state   <= ABORT;
                phase   <= '0;
                cnt_clk <= 1'b0;
                cnt_clr <= 1'b1;
                count   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state   <= CLEAR;
                            phase   <= '0;
                            tgt     <= target;
                            err     <= 1'b0;
                            count   <= '0;
                            cnt_clk <= 1'b0;
                            cnt_clr <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        if (phase == CLR_LAST) begin
                            state   <= SETTLE;
                            phase   <= '0;
                            cnt_clr <= 1'b0;
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (phase == SETTLE_LAST) begin
                            state <= CHECK;
                            phase <= '0;
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    CHECK: begin
                        // Only state in which the asynchronous counter outputs are looked at.
                        if (cnt_q != count) begin
                            err   <= 1'b1;
                            state <= FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (count == tgt) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state   <= PULSE_HI;
                            phase   <= '0;
                            cnt_clk <= 1'b1;
                        end
                    end
                    PULSE_HI: begin
                        if (phase == HIGH_LAST) begin
                            // Shadow count advances with the falling edge the counter responds to.
                            state   <= PULSE_LO;
                            phase   <= '0;
                            cnt_clk <= 1'b0;
                            count   <= count + WIDTH'(1);
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    PULSE_LO: begin
                        if (phase == LOW_LAST) begin
                            state <= SETTLE;
                            phase <= '0;
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                    end
                    ABORT: begin
                        if (phase == CLR_LAST) begin
                            state <= IDLE;
                            phase <= '0;
                            busy  <= 1'b0;
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_4040_seq.sv
// Scoreboard bench for counter_4040_seq driving a behavioural 744040 model.
module tb_counter_4040_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [11:0] target;
    logic        abort;
    logic [11:0] cnt_q;
    logic        cnt_clk;
    logic        cnt_clr;
    logic        busy;
    logic        done;
    logic        err;
    logic [11:0] count;

    logic [11:0] ripple = 12'd0;
    logic        stuck_b0 = 1'b0;
    int          edge_n = 0;
    int          fall_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        logic [11:0] cnt;
        logic        e;
        logic [11:0] cq;
        int          when;
    } exp_t;

    exp_t sb[$];

    counter_4040_seq dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .target (target),
        .abort  (abort),
        .cnt_q  (cnt_q),
        .cnt_clk(cnt_clk),
        .cnt_clr(cnt_clr),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .count  (count)
    );

    // 40 ns system clock
    always #20 clk = ~clk;

    // 744040 model: falling-edge clocked, asynchronous active-high clear
    always @(negedge cnt_clk or posedge cnt_clr) begin
        if (cnt_clr) ripple <= 12'd0;
        else         ripple <= ripple + 12'd1;
    end

    assign cnt_q = stuck_b0 ? {ripple[11:1], 1'b0} : ripple;

    always @(posedge clk) edge_n <= edge_n + 1;
    always @(negedge cnt_clk) fall_cnt <= fall_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", 32'(edge_n), 32'(e.when));
                chk("done_count", 32'(count), 32'(e.cnt));
                chk("done_err", 32'(err), 32'(e.e));
                chk("done_cnt_q", 32'(cnt_q), 32'(e.cq));
                chk("done_busy", 32'(busy), 32'd0);
            end
        end
    end

    int fall_base;

    // Issue a start; if push, the expected done record goes to the scoreboard
    task automatic issue(input logic [11:0] t, input bit push, input int steps,
                         input logic [11:0] exp_cnt, input bit exp_err, input logic [11:0] exp_cq);
        exp_t e;
        @(negedge clk);
        if (push) begin
            e.cnt  = exp_cnt;
            e.e    = exp_err;
            e.cq   = exp_cq;
            e.when = edge_n + 8 + 7 * steps;
            sb.push_back(e);
        end
        start     = 1'b1;
        target    = t;
        fall_base = fall_cnt;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("err_cleared_on_start", 32'(err), 32'd0);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: %0d results still pending after %0d cycles", sb.size(), budget);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        clr    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        target = 12'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cnt_clr", 32'(cnt_clr), 32'd1);
        chk("rst_cnt_clk", 32'(cnt_clk), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        // target 0: only the clear check
        issue(12'd0, 1'b1, 0, 12'd0, 1'b0, 12'd0);
        wait_done(40);
        chk("t0_falls", 32'(fall_cnt - fall_base), 32'd0);

        // target 3: three falling edges, done at cycle 29
        issue(12'd3, 1'b1, 3, 12'd3, 1'b0, 12'd3);
        wait_done(60);
        chk("t3_falls", 32'(fall_cnt - fall_base), 32'd3);
        chk("t3_hold_count", 32'(count), 32'd3);
        chk("t3_hold_cnt_q", 32'(cnt_q), 32'd3);

        // bit 0 stuck low: mismatch after first pulse
        stuck_b0 = 1'b1;
        issue(12'd2, 1'b1, 1, 12'd1, 1'b1, 12'd0);
        wait_done(60);
        chk("fault_err_sticky", 32'(err), 32'd1);
        chk("fault_falls", 32'(fall_cnt - fall_base), 32'd1);
        stuck_b0 = 1'b0;
        issue(12'd0, 1'b1, 0, 12'd0, 1'b0, 12'd0);
        wait_done(40);

        // abort in the middle of a target=10 run
        issue(12'd10, 1'b0, 0, 12'd0, 1'b0, 12'd0);
        repeat (13) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_clr_1", 32'(cnt_clr), 32'd1);
        chk("abort_busy_1", 32'(busy), 32'd1);
        chk("abort_count", 32'(count), 32'd0);
        @(negedge clk);
        chk("abort_clr_2", 32'(cnt_clr), 32'd1);
        @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_cnt_q", 32'(cnt_q), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        // start together with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        target = 12'd4;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_ignored", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        chk("start_abort_no_run", 32'(busy), 32'd0);

        // synchronous reset mid-run, then a clean run to 5
        issue(12'd5, 1'b0, 0, 12'd0, 1'b0, 12'd0);
        repeat (18) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("midrst_cnt_clr", 32'(cnt_clr), 32'd1);
        chk("midrst_cnt_clk", 32'(cnt_clk), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        clr = 1'b0;
        @(negedge clk);
        issue(12'd5, 1'b1, 5, 12'd5, 1'b0, 12'd5);
        wait_done(80);
        chk("t5_falls", 32'(fall_cnt - fall_base), 32'd5);

        // full-scale run: no wrap
        issue(12'hFFF, 1'b1, 4095, 12'hFFF, 1'b0, 12'hFFF);
        wait_done(8 + 4095 * 7 + 40);
        chk("tfff_falls", 32'(fall_cnt - fall_base), 32'd4095);
        chk("tfff_hold_count", 32'(count), 32'hFFF);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
